// File: rtl/uart_tx_arb.sv
// Message-granular round-robin arbiter feeding one UART TX FIFO; optional idle timeout under UART_TX_ARB_TIMEOUT_EN.
// Latency: 1 IDLE cycle to grant, then bytes pass combinationally to fifo_wr/fifo_wdata.
// Backpressure: fifo_full drops req_ready of the granted requester; the grant is held until the last byte.
module uart_tx_arb #(
    parameter int NREQ = 4,
    parameter int TW   = 8
) (
    input  logic              app_clk,
    input  logic              reset,
    input  logic              cfg_arb_enable,
    input  logic [TW-1:0]     cfg_timeout,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [7:0]        fifo_wdata,
    output logic              arb_busy,
    output logic [2:0]        arb_grant_id,
    output logic [15:0]       arb_byte_cnt,
    output logic              arb_err
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q, state_d;
    logic [2:0]  last_grant_q, last_grant_d;
    logic [2:0]  grant_q, grant_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;

    logic        sel_valid, sel_last;
    logic [7:0]  sel_data;
    logic        found;
    logic [2:0]  win;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout;
`endif

    always_ff @(posedge app_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 3'(NREQ-1);
            grant_q      <= 3'd0;
            byte_cnt_q   <= 16'd0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            byte_cnt_q   <= byte_cnt_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req_valid[j] && ((int'(last_grant_q) + k) % NREQ) == j) begin
                    found = 1'b1;
                    win   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        byte_cnt_d   = byte_cnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_arb_enable && found) begin
                    state_d    = XFER;
                    grant_d    = win;
                    byte_cnt_d = 16'd0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            XFER: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                tmo_d = sel_valid ? '0 : tmo_q + TW'(1);
`endif
                if (fifo_wr) begin
                    if (byte_cnt_q != 16'hFFFF)
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    if (sel_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
                if (arb_err) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == 3'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
        req_ready  = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = 8'd0;
        arb_err    = 1'b0;
        // Gated by reset so a mid-message reset drops the strobes in the same cycle.
        if (state_q == XFER && !reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q == 3'(i))
                    req_ready[i] = !fifo_full;
            end
            fifo_wr = sel_valid && !fifo_full;
            if (fifo_wr)
                fifo_wdata = sel_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
            arb_err = !sel_valid && (cfg_timeout != '0) && ((tmo_q + TW'(1)) == cfg_timeout);
`endif
        end
    end

    assign arb_busy     = (state_q == XFER);
    assign arb_grant_id = grant_q;
    assign arb_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: requester byte queues, expected-write scoreboard, immediate assertions.
// Covers both builds of UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int TW   = 8;

    logic              app_clk = 1'b0;
    logic              reset;
    logic              cfg_arb_enable;
    logic [TW-1:0]     cfg_timeout;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_wr;
    logic [7:0]        fifo_wdata;
    logic              arb_busy;
    logic [2:0]        arb_grant_id;
    logic [15:0]       arb_byte_cnt;
    logic              arb_err;

    uart_tx_arb #(.NREQ(NREQ), .TW(TW)) dut (
        .app_clk(app_clk), .reset(reset), .cfg_arb_enable(cfg_arb_enable),
        .cfg_timeout(cfg_timeout), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .arb_busy(arb_busy),
        .arb_grant_id(arb_grant_id), .arb_byte_cnt(arb_byte_cnt), .arb_err(arb_err)
    );

    always #5 app_clk = ~app_clk;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int t0;

    logic [8:0]  rq [NREQ][$];
    logic [10:0] sb [$];
    int          wr_log [$];
    int          err_log [$];

    logic          drive_rst, drive_en, drive_full;
    logic [TW-1:0] drive_tmo;
    logic          s_wr, s_busy, s_err;
    logic [NREQ-1:0] s_ready;
    logic [2:0]    s_grant;
    logic [15:0]   s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int r, input logic [7:0] b, input logic last, input logic exp);
        rq[r].push_back({last, b});
        if (exp) sb.push_back({3'(r), b});
    endtask

    // One clock: drive at negedge, sample 1 time unit later, retire accepted bytes at posedge.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        logic [10:0] e;
        @(negedge app_clk);
        reset          = drive_rst;
        cfg_arb_enable = drive_en;
        fifo_full      = drive_full;
        cfg_timeout    = drive_tmo;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'd0;
                req_last[i]        = 1'b0;
            end
        end
        #1;
        cyc_n++;
        s_wr = fifo_wr; s_busy = arb_busy; s_err = arb_err;
        s_ready = req_ready; s_grant = arb_grant_id; s_cnt = arb_byte_cnt;
        if (arb_err === 1'b1) err_log.push_back(cyc_n);
        acc = req_ready & req_valid;
        if (fifo_wr !== (|acc)) begin
            chk("wr_vs_ready", fifo_wr, |acc);
        end
        if (fifo_wr === 1'b1) begin
            wr_log.push_back(cyc_n);
            if (sb.size() == 0) begin
                chk("unexpected_write", fifo_wdata, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wdata", fifo_wdata, e[7:0]);
                chk("write_grant", arb_grant_id, e[10:8]);
            end
        end
        @(posedge app_clk);
        for (int i = 0; i < NREQ; i++)
            if (acc[i]) void'(rq[i].pop_front());
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        sb.delete();
        drive_rst = 1'b1;
        run(2);
        drive_rst = 1'b0;
        wr_log.delete();
        err_log.delete();
        t0 = cyc_n;
    endtask

    initial begin
        reset = 1'b1; cfg_arb_enable = 1'b1; cfg_timeout = '0; req_valid = '0;
        req_data = '0; req_last = '0; fifo_full = 1'b0;
        drive_rst = 1'b1; drive_en = 1'b1; drive_full = 1'b0; drive_tmo = '0;

        // Reset state
        do_reset();
        #2;
        chk("rst_busy", arb_busy, 0);
        chk("rst_grant", arb_grant_id, 0);
        chk("rst_cnt", arb_byte_cnt, 0);
        chk("rst_err", arb_err, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr", fifo_wr, 0);
        chk("rst_wdata", fifo_wdata, 0);

        // Two 3-byte messages: requester 0 then 2, one IDLE gap
        put(0, 8'h11, 0, 1); put(0, 8'h22, 0, 1); put(0, 8'h33, 1, 1);
        put(2, 8'hA1, 0, 1); put(2, 8'hA2, 0, 1); put(2, 8'hA3, 1, 1);
        run(9);
        chk("t1_nwr", wr_log.size(), 6);
        if (wr_log.size() == 6) begin
            chk("t1_w0", wr_log[0] - t0, 2);
            chk("t1_w2", wr_log[2] - t0, 4);
            chk("t1_w3", wr_log[3] - t0, 6);
            chk("t1_w5", wr_log[5] - t0, 8);
        end
        chk("t1_sb", sb.size(), 0);
        chk("t1_grant_hold", s_grant, 2);
        chk("t1_cnt_hold", s_cnt, 3);
        chk("t1_busy", s_busy, 0);

        // Round robin of 1-byte messages over all four requesters
        do_reset();
        put(0, 8'h40, 1, 1); put(1, 8'h41, 1, 1); put(2, 8'h42, 1, 1);
        put(3, 8'h43, 1, 1); put(0, 8'h44, 1, 1); put(1, 8'h45, 1, 1);
        run(14);
        chk("t2_nwr", wr_log.size(), 6);
        for (int k = 0; k < wr_log.size(); k++) chk("t2_gap", wr_log[k] - t0, 2 * k + 2);
        chk("t2_sb", sb.size(), 0);
        chk("t2_cnt1", s_cnt, 1);

        // FIFO full for 5 cycles mid-message of requester 1
        do_reset();
        put(1, 8'hB0, 0, 1); put(1, 8'hB1, 0, 1); put(1, 8'hB2, 0, 1); put(1, 8'hB3, 1, 1);
        run(2);
        drive_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_wr", s_wr, 0);
            chk("t3_ready", s_ready, 0);
            chk("t3_grant", s_grant, 1);
            chk("t3_busy", s_busy, 1);
        end
        chk("t3_cnt_stall", s_cnt, 1);
        drive_full = 1'b0;
        run(6);
        chk("t3_sb", sb.size(), 0);
        chk("t3_cnt", s_cnt, 4);

        // Enable dropped during byte 2 of 4 from requester 3
        do_reset();
        put(3, 8'hD0, 0, 1); put(3, 8'hD1, 0, 1); put(3, 8'hD2, 0, 1); put(3, 8'hD3, 1, 1);
        run(2);
        drive_en = 1'b0;
        run(4);
        chk("t4_nwr", wr_log.size(), 4);
        chk("t4_sb", sb.size(), 0);
        wr_log.delete();
        put(0, 8'hE0, 1, 1); put(1, 8'hE1, 1, 1); put(2, 8'hE2, 1, 1); put(3, 8'hE3, 1, 1);
        run(10);
        chk("t4_disabled_nwr", wr_log.size(), 0);
        chk("t4_disabled_busy", s_busy, 0);
        drive_en = 1'b1;
        run(10);
        chk("t4_resume_sb", sb.size(), 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Timeout abort after 10 idle cycles, then requester 1 wins
        do_reset();
        drive_tmo = 8'd10;
        put(0, 8'hF0, 0, 1); put(1, 8'hF1, 1, 1);
        run(16);
        chk("t5_nerr", err_log.size(), 1);
        if (err_log.size() == 1) chk("t5_err_cyc", err_log[0] - t0, 12);
        chk("t5_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) chk("t5_next_wr", wr_log[1] - t0, 14);
        chk("t5_sb", sb.size(), 0);
        do_reset();
        drive_tmo = 8'd0;
        put(0, 8'hF2, 0, 1);
        run(1000);
        chk("t5_noabort_err", err_log.size(), 0);
        chk("t5_noabort_busy", s_busy, 1);
        chk("t5_noabort_grant", s_grant, 0);
`else
        // Without the timeout build a stalled requester keeps the grant
        do_reset();
        drive_tmo = 8'd10;
        put(0, 8'hF0, 0, 1); put(1, 8'hF1, 1, 0);
        run(40);
        chk("t5_err_tied", err_log.size(), 0);
        chk("t5_hold_busy", s_busy, 1);
        chk("t5_hold_grant", s_grant, 0);
        chk("t5_sb", sb.size(), 0);
        drive_tmo = 8'd0;
`endif

        // Reset mid-message of requester 2; arbitration restarts at requester 0
        do_reset();
        put(0, 8'h55, 1, 1);
        put(2, 8'hC1, 0, 1); put(2, 8'hC2, 0, 1); put(2, 8'hC3, 0, 0); put(2, 8'hC4, 1, 0);
        run(5);
        chk("t6_pre_busy", s_busy, 1);
        drive_rst = 1'b1;
        cycle();
        chk("t6_rst_wr", s_wr, 0);
        chk("t6_rst_ready", s_ready, 0);
        drive_rst = 1'b0;
        put(0, 8'h66, 1, 1);
        sb.push_back({3'd2, 8'hC3});
        sb.push_back({3'd2, 8'hC4});
        cycle();
        chk("t6_busy", s_busy, 0);
        chk("t6_wr", s_wr, 0);
        chk("t6_grant", s_grant, 0);
        chk("t6_cnt", s_cnt, 0);
        run(6);
        chk("t6_sb", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
